ip2_scan_out_capture: RTL and testbench

- Receive side of the scan-chain serial test. This block samples the ASIC scan_out pin once per slow scan-clock period while the scan chain is in shift mode.
- It assembles SCAN_LEN received bits into a shift register, compares each bit on the fly against an expected bit, and counts mismatches.
- It sits beside the scan-in test state machines in the FW test slot. Software reads the captured data back through a 32-bit word select.

---
 rtl/ip2_pkg.sv | 21 ++
 rtl/ip2_scan_word_mux.sv | 24 ++
 rtl/ip2_scan_out_capture.sv | 120 ++++++++++++
 tb/tb_ip2_scan_out_capture.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip2_pkg.sv
// Shared types and sizing for the IP2 scan-chain test slot.
package ip2_pkg;

    localparam int unsigned IP2_SCAN_LEN = 768;
    localparam int unsigned IP2_CNT_W    = 10;
    localparam int unsigned WORD_W       = 32;
    localparam int unsigned SCAN_WORDS   = IP2_SCAN_LEN / WORD_W;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_ARMED   = 2'd1,
        CAP_CAPTURE = 2'd2,
        CAP_DONE    = 2'd3
    } cap_state_t;

    typedef enum logic {
        SHIFT_REG = 1'b0,
        LOAD_COMP = 1'b1
    } scan_chain_mode_t;

endpackage

// File: rtl/ip2_scan_word_mux.sv
// Selects one 32-bit word of the capture register for software read-back.
module ip2_scan_word_mux
    import ip2_pkg::*;
#(
    parameter int unsigned SCAN_LEN = IP2_SCAN_LEN
) (
    input  logic [SCAN_LEN-1:0] data,
    input  logic [4:0]          word_sel,
    output logic [WORD_W-1:0]   word
);

    localparam int unsigned WORDS = SCAN_LEN / WORD_W;

    // Out-of-range selects fall through to zero.
    always_comb begin
        word = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (32'(word_sel) == i) begin
                word = data[WORD_W*i +: WORD_W];
            end
        end
    end

endmodule

// File: rtl/ip2_scan_out_capture.sv
// Samples the ASIC scan_out pin once per slow scan-clock period, assembles the
// chain into a register and counts bits that differ from the expected stream.
module ip2_scan_out_capture
    import ip2_pkg::*;
#(
    parameter int unsigned SCAN_LEN = IP2_SCAN_LEN,
    parameter int unsigned CNT_W    = IP2_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [5:0]        clk_counter,
    input  logic [5:0]        sample_delay,
    input  logic              capture_start_re,
    input  logic              scan_load,
    input  logic              scan_out,
    input  logic              exp_bit,
    input  logic [4:0]        word_sel,
    output logic [1:0]        cap_state,
    output logic [31:0]       cap_word,
    output logic [CNT_W-1:0]  cap_bit_cnt,
    output logic [CNT_W-1:0]  cap_err_cnt,
    output logic              cap_busy,
    output logic              cap_done,
    output logic              cap_error
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SCAN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    cap_state_t          state;
    logic [SCAN_LEN-1:0] cap_reg;
    logic                sample_hit;
    logic                mismatch;
    scan_chain_mode_t    chain_mode;

    assign sample_hit = (clk_counter == sample_delay);
    assign mismatch   = (scan_out != exp_bit);
    assign chain_mode = scan_chain_mode_t'(scan_load);
    assign cap_state  = 2'(state);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= CAP_IDLE;
            cap_reg     <= '0;
            cap_bit_cnt <= '0;
            cap_err_cnt <= '0;
            cap_busy    <= 1'b0;
            cap_done    <= 1'b0;
            cap_error   <= 1'b0;
        end else if (!enable) begin
            // Disabling aborts the run but keeps data and status for read-back.
            state    <= CAP_IDLE;
            cap_busy <= 1'b0;
        end else begin
            case (state)
                CAP_IDLE: begin
                    if (capture_start_re) begin
                        state       <= CAP_ARMED;
                        cap_reg     <= '0;
                        cap_bit_cnt <= '0;
                        cap_err_cnt <= '0;
                        cap_busy    <= 1'b1;
                        cap_done    <= 1'b0;
                        cap_error   <= 1'b0;
                    end
                end
                CAP_ARMED: begin
                    if (sample_hit && chain_mode == SHIFT_REG) begin
                        state <= CAP_CAPTURE;
                    end
                end
                CAP_CAPTURE: begin
                    if (sample_hit) begin
                        if (chain_mode == LOAD_COMP) begin
                            // Chain left shift mode before the last bit arrived.
                            state     <= CAP_DONE;
                            cap_error <= 1'b1;
                            cap_busy  <= 1'b0;
                            cap_done  <= 1'b1;
                        end else begin
                            cap_reg     <= {scan_out, cap_reg[SCAN_LEN-1:1]};
                            cap_bit_cnt <= cap_bit_cnt + CNT_ONE;
                            if (mismatch) begin
                                if (cap_err_cnt != CNT_MAX) begin
                                    cap_err_cnt <= cap_err_cnt + CNT_ONE;
                                end
                                cap_error <= 1'b1;
                            end
                            if (cap_bit_cnt == LAST_BIT) begin
                                state    <= CAP_DONE;
                                cap_busy <= 1'b0;
                                cap_done <= 1'b1;
                            end
                        end
                    end
                end
                CAP_DONE: begin
                    state    <= CAP_IDLE;
                    cap_busy <= 1'b0;
                    cap_done <= 1'b1;
                end
                default: begin
                    state    <= CAP_IDLE;
                    cap_busy <= 1'b0;
                end
            endcase
        end
    end

    ip2_scan_word_mux #(
        .SCAN_LEN (SCAN_LEN)
    ) u_word_mux (
        .data     (cap_reg),
        .word_sel (word_sel),
        .word     (cap_word)
    );

endmodule

// File: tb/tb_ip2_scan_out_capture.sv
// Randomised self-checking bench for ip2_scan_out_capture against a queue model.
module tb_ip2_scan_out_capture;
    import ip2_pkg::*;

    localparam int unsigned SL     = IP2_SCAN_LEN;
    localparam int unsigned CW     = IP2_CNT_W;
    localparam int unsigned NW     = SL / 32;
    localparam int unsigned PERIOD = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic [5:0]    clk_counter = 6'd0;
    logic [5:0]    sample_delay = 6'd10;
    logic          capture_start_re = 1'b0;
    logic          scan_load = 1'b1;
    logic          scan_out = 1'b0;
    logic          exp_bit = 1'b0;
    logic [4:0]    word_sel = 5'd0;
    logic [1:0]    cap_state;
    logic [31:0]   cap_word;
    logic [CW-1:0] cap_bit_cnt;
    logic [CW-1:0] cap_err_cnt;
    logic          cap_busy;
    logic          cap_done;
    logic          cap_error;

    int total = 0;
    int bad = 0;

    // Stimulus streams and the reference model: received bits in arrival order.
    bit tx [SL];
    bit ex [SL];
    bit q [$];
    int m_errs;
    bit m_err_flag;

    ip2_scan_out_capture dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .clk_counter      (clk_counter),
        .sample_delay     (sample_delay),
        .capture_start_re (capture_start_re),
        .scan_load        (scan_load),
        .scan_out         (scan_out),
        .exp_bit          (exp_bit),
        .word_sel         (word_sel),
        .cap_state        (cap_state),
        .cap_word         (cap_word),
        .cap_bit_cnt      (cap_bit_cnt),
        .cap_err_cnt      (cap_err_cnt),
        .cap_busy         (cap_busy),
        .cap_done         (cap_done),
        .cap_error        (cap_error)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one clock; clk_counter then holds the phase the next edge sees.
    task automatic tick();
        @(posedge clk);
        #1;
        clk_counter = (clk_counter == 6'(PERIOD - 1)) ? 6'd0 : clk_counter + 6'd1;
    endtask

    // After n arrivals the newest bit is at SL-1 and the oldest at SL-n.
    function automatic logic [31:0] model_word(input int w);
        logic [31:0] word;
        int n;
        int pos;
        word = 32'h0;
        n = q.size();
        if (w < int'(NW)) begin
            for (int b = 0; b < 32; b++) begin
                pos = 32 * w + b - (int'(SL) - n);
                if (pos >= 0) word[b] = q[pos];
            end
        end
        return word;
    endfunction

    task automatic model_clear();
        q.delete();
        m_errs = 0;
        m_err_flag = 1'b0;
    endtask

    task automatic start_run();
        capture_start_re = 1'b1;
        tick();
        capture_start_re = 1'b0;
        model_clear();
    endtask

    task automatic arm();
        scan_load = 1'b0;
        while (clk_counter != sample_delay) tick();
        tick();
    endtask

    task automatic feed(input int count);
        for (int k = 0; k < count; k++) begin
            while (clk_counter != sample_delay) begin
                scan_out = 1'($urandom);
                exp_bit = 1'($urandom);
                tick();
            end
            scan_out = tx[q.size()];
            exp_bit = ex[q.size()];
            if (tx[q.size()] != ex[q.size()]) begin
                m_errs++;
                m_err_flag = 1'b1;
            end
            q.push_back(tx[q.size()]);
            tick();
        end
    endtask

    task automatic rand_streams();
        for (int i = 0; i < int'(SL); i++) begin
            tx[i] = 1'($urandom);
            ex[i] = ($urandom_range(3) == 0) ? ~tx[i] : tx[i];
        end
        sample_delay = 6'($urandom_range(PERIOD - 1));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        total++; if (cap_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", cap_state); end
        total++; if (cap_bit_cnt !== '0) begin bad++; $display("FAIL reset_bit_cnt got=%0d want=0", cap_bit_cnt); end
        total++; if (cap_err_cnt !== '0) begin bad++; $display("FAIL reset_err_cnt got=%0d want=0", cap_err_cnt); end
        total++; if ({cap_busy, cap_done, cap_error} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {cap_busy, cap_done, cap_error}); end
        total++; if (cap_word !== 32'h0) begin bad++; $display("FAIL reset_word got=%h want=0", cap_word); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_pattern();
        sample_delay = 6'd10;
        for (int i = 0; i < int'(SL); i++) begin
            tx[i] = (i % 2 == 0);
            ex[i] = tx[i];
        end
        scan_load = 1'b1;
        start_run();
        total++; if (cap_state !== 2'd1 || cap_busy !== 1'b1) begin bad++; $display("FAIL pat_armed state=%0d busy=%b want 1/1", cap_state, cap_busy); end
        arm();
        total++; if (cap_state !== 2'd2) begin bad++; $display("FAIL pat_capture_state got=%0d want=2", cap_state); end
        for (int k = 0; k < int'(SL); k++) begin
            feed(1);
            total++; if (cap_bit_cnt !== CW'(q.size())) begin bad++; $display("FAIL pat_bit_latency got=%0d want=%0d", cap_bit_cnt, q.size()); end
        end
        total++; if (cap_state !== 2'd3 || cap_done !== 1'b1 || cap_busy !== 1'b0) begin bad++; $display("FAIL pat_done state=%0d done=%b busy=%b want 3/1/0", cap_state, cap_done, cap_busy); end
        tick();
        total++; if (cap_state !== 2'd0 || cap_done !== 1'b1) begin bad++; $display("FAIL pat_idle state=%0d done=%b want 0/1", cap_state, cap_done); end
        total++; if (cap_err_cnt !== '0 || cap_error !== 1'b0) begin bad++; $display("FAIL pat_errors cnt=%0d err=%b want 0/0", cap_err_cnt, cap_error); end
        for (int w = 0; w < 32; w++) begin
            word_sel = 5'(w);
            #1;
            total++; if (cap_word !== model_word(w)) begin bad++; $display("FAIL pat_word[%0d] got=%h want=%h", w, cap_word, model_word(w)); end
        end
        word_sel = 5'd7;
        #1;
        total++; if (cap_word !== 32'h55555555) begin bad++; $display("FAIL pat_word_const got=%h want=55555555", cap_word); end
    endtask

    task automatic test_errors();
        for (int i = 0; i < int'(SL); i++) begin
            tx[i] = 1'b0;
            ex[i] = 1'b0;
        end
        tx[5] = 1'b1;
        tx[100] = 1'b1;
        tx[767] = 1'b1;
        sample_delay = 6'($urandom_range(PERIOD - 1));
        scan_load = 1'b1;
        start_run();
        total++; if (cap_done !== 1'b0) begin bad++; $display("FAIL err_done_cleared got=%b want=0", cap_done); end
        arm();
        feed(SL);
        tick();
        total++; if (cap_err_cnt !== CW'(3) || cap_err_cnt !== CW'(m_errs)) begin bad++; $display("FAIL err_cnt got=%0d want=3", cap_err_cnt); end
        total++; if (cap_error !== 1'b1) begin bad++; $display("FAIL err_flag got=%b want=1", cap_error); end
        word_sel = 5'd0;
        #1;
        total++; if (cap_word !== 32'h00000020) begin bad++; $display("FAIL err_word0 got=%h want=00000020", cap_word); end
        word_sel = 5'd3;
        #1;
        total++; if (cap_word !== 32'h00000010) begin bad++; $display("FAIL err_word3 got=%h want=00000010", cap_word); end
        word_sel = 5'd23;
        #1;
        total++; if (cap_word !== 32'h80000000) begin bad++; $display("FAIL err_word23 got=%h want=80000000", cap_word); end
    endtask

    task automatic test_early_exit();
        rand_streams();
        scan_load = 1'b1;
        start_run();
        arm();
        feed(200);
        scan_load = 1'b1;
        while (clk_counter != sample_delay) begin
            scan_out = 1'($urandom);
            tick();
        end
        tick();
        total++; if (cap_state !== 2'd3 || cap_bit_cnt !== CW'(200) || cap_error !== 1'b1) begin bad++; $display("FAIL early_done state=%0d cnt=%0d err=%b want 3/200/1", cap_state, cap_bit_cnt, cap_error); end
        tick();
        total++; if (cap_state !== 2'd0 || cap_done !== 1'b1 || cap_bit_cnt !== CW'(200)) begin bad++; $display("FAIL early_idle state=%0d done=%b cnt=%0d want 0/1/200", cap_state, cap_done, cap_bit_cnt); end
        total++; if (cap_err_cnt !== CW'(m_errs)) begin bad++; $display("FAIL early_err_cnt got=%0d want=%0d", cap_err_cnt, m_errs); end
        for (int w = 16; w < int'(NW); w++) begin
            word_sel = 5'(w);
            #1;
            total++; if (cap_word !== model_word(w)) begin bad++; $display("FAIL early_word[%0d] got=%h want=%h", w, cap_word, model_word(w)); end
        end
    endtask

    task automatic test_reset_mid();
        rand_streams();
        scan_load = 1'b1;
        start_run();
        arm();
        feed(300);
        word_sel = 5'd23;
        reset = 1'b1;
        #1;
        model_clear();
        total++; if (cap_state !== 2'd0 || cap_bit_cnt !== '0 || cap_err_cnt !== '0) begin bad++; $display("FAIL rst_mid state=%0d cnt=%0d err=%0d want 0/0/0", cap_state, cap_bit_cnt, cap_err_cnt); end
        total++; if ({cap_busy, cap_done, cap_error} !== 3'b000 || cap_word !== 32'h0) begin bad++; $display("FAIL rst_mid_flags flags=%b word=%h want 000/0", {cap_busy, cap_done, cap_error}, cap_word); end
        repeat (2) tick();
        reset = 1'b0;
        tick();
        rand_streams();
        scan_load = 1'b1;
        start_run();
        arm();
        feed(SL);
        tick();
        total++; if (cap_bit_cnt !== CW'(SL) || cap_done !== 1'b1) begin bad++; $display("FAIL rst_full cnt=%0d done=%b want 768/1", cap_bit_cnt, cap_done); end
        total++; if (cap_err_cnt !== CW'(m_errs) || cap_error !== m_err_flag) begin bad++; $display("FAIL rst_full_err cnt=%0d flag=%b want %0d/%b", cap_err_cnt, cap_error, m_errs, m_err_flag); end
        for (int w = 0; w < int'(NW); w++) begin
            word_sel = 5'(w);
            #1;
            total++; if (cap_word !== model_word(w)) begin bad++; $display("FAIL rst_word[%0d] got=%h want=%h", w, cap_word, model_word(w)); end
        end
    endtask

    task automatic test_enable_restart();
        rand_streams();
        scan_load = 1'b1;
        start_run();
        arm();
        feed(150);
        enable = 1'b0;
        tick();
        total++; if (cap_state !== 2'd0 || cap_busy !== 1'b0) begin bad++; $display("FAIL en_abort state=%0d busy=%b want 0/0", cap_state, cap_busy); end
        repeat (3) tick();
        total++; if (cap_bit_cnt !== CW'(150) || cap_err_cnt !== CW'(m_errs)) begin bad++; $display("FAIL en_hold cnt=%0d err=%0d want 150/%0d", cap_bit_cnt, cap_err_cnt, m_errs); end
        for (int w = 19; w < int'(NW); w++) begin
            word_sel = 5'(w);
            #1;
            total++; if (cap_word !== model_word(w)) begin bad++; $display("FAIL en_word[%0d] got=%h want=%h", w, cap_word, model_word(w)); end
        end
        enable = 1'b1;
        tick();
        rand_streams();
        scan_load = 1'b1;
        start_run();
        total++; if (cap_state !== 2'd1 || cap_bit_cnt !== '0 || cap_err_cnt !== '0) begin bad++; $display("FAIL en_restart state=%0d cnt=%0d err=%0d want 1/0/0", cap_state, cap_bit_cnt, cap_err_cnt); end
        total++; if (cap_done !== 1'b0 || cap_error !== 1'b0) begin bad++; $display("FAIL en_restart_flags done=%b err=%b want 0/0", cap_done, cap_error); end
        word_sel = 5'd23;
        #1;
        total++; if (cap_word !== 32'h0) begin bad++; $display("FAIL en_restart_word got=%h want=0", cap_word); end
        arm();
        feed(50);
        capture_start_re = 1'b1;
        tick();
        capture_start_re = 1'b0;
        total++; if (cap_state !== 2'd2 || cap_bit_cnt !== CW'(50)) begin bad++; $display("FAIL en_start_ignored state=%0d cnt=%0d want 2/50", cap_state, cap_bit_cnt); end
        feed(SL - 50);
        tick();
        total++; if (cap_bit_cnt !== CW'(SL) || cap_err_cnt !== CW'(m_errs) || cap_error !== m_err_flag) begin bad++; $display("FAIL en_full cnt=%0d err=%0d flag=%b want 768/%0d/%b", cap_bit_cnt, cap_err_cnt, cap_error, m_errs, m_err_flag); end
        for (int w = 0; w < int'(NW); w += 5) begin
            word_sel = 5'(w);
            #1;
            total++; if (cap_word !== model_word(w)) begin bad++; $display("FAIL en_full_word[%0d] got=%h want=%h", w, cap_word, model_word(w)); end
        end
    endtask

    task automatic test_armed_wait();
        bit hit;
        bit seen;
        rand_streams();
        scan_load = 1'b1;
        start_run();
        repeat (1000) begin
            scan_out = 1'($urandom);
            tick();
        end
        total++; if (cap_state !== 2'd1 || cap_bit_cnt !== '0 || cap_busy !== 1'b1) begin bad++; $display("FAIL armed_hold state=%0d cnt=%0d busy=%b want 1/0/1", cap_state, cap_bit_cnt, cap_busy); end
        while (clk_counter != 6'((32'(sample_delay) + 3) % PERIOD)) tick();
        scan_load = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < int'(2 * PERIOD) && !seen; c++) begin
            hit = (clk_counter == sample_delay);
            tick();
            total++; if (cap_state !== (hit ? 2'd2 : 2'd1)) begin bad++; $display("FAIL armed_phase state=%0d want=%0d", cap_state, hit ? 2 : 1); end
            seen = hit;
        end
        total++; if (!seen || cap_state !== 2'd2) begin bad++; $display("FAIL armed_enter state=%0d want=2", cap_state); end
        feed(20);
        total++; if (cap_bit_cnt !== CW'(20)) begin bad++; $display("FAIL armed_feed cnt=%0d want=20", cap_bit_cnt); end
        enable = 1'b0;
        tick();
        total++; if (cap_state !== 2'd0 || cap_bit_cnt !== CW'(20)) begin bad++; $display("FAIL armed_abort state=%0d cnt=%0d want 0/20", cap_state, cap_bit_cnt); end
        enable = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_errors();
        test_early_exit();
        test_reset_mid();
        test_enable_restart();
        test_armed_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
